// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect definitions: master count, write-arbiter
// state encoding and the response code used for synthetic error replies.
package axil_pkg;

  localparam int NUMBER_MASTER = 4;

  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR_DATA,
    RESP,
    ERR
  } axil_wr_arb_state_t;

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit after
// last_idx, wrapping modulo N. Shared by the read and write arbiters.
module axil_rr_pick #(
  parameter  int N  = axil_pkg::NUMBER_MASTER,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  // Scan candidates last_idx+1 .. last_idx+N and keep the first requester.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // through the block leaves a value held and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_idx) + i) % N);
      if (!valid && request[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axil_arbiter_rr_wr_wdog.sv
// Round-robin write-channel arbiter. Holds the grant over a full AW/W/B
// transaction and aborts a stalled one with a synthetic SLVERR B response.
module axil_arbiter_rr_wr_wdog #(
  parameter  int NUMBER_MASTER  = axil_pkg::NUMBER_MASTER,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int IDX_W          = $clog2(NUMBER_MASTER),
  localparam int WD_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] request_wr,
  output logic [NUMBER_MASTER-1:0] grant_wr,
  output logic [IDX_W-1:0]         grant_idx,
  input  logic                     s_axil_awvalid,
  input  logic                     s_axil_awready,
  input  logic                     s_axil_wvalid,
  input  logic                     s_axil_wready,
  input  logic                     s_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0] m_axil_bready,
  output logic [NUMBER_MASTER-1:0] err_bvalid,
  output logic                     timeout
);

  import axil_pkg::*;

  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  axil_wr_arb_state_t       state_q, state_d;
  logic [NUMBER_MASTER-1:0] grant_q, grant_d;
  logic [NUMBER_MASTER-1:0] err_q, err_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic                     timeout_q, timeout_d;

  logic [NUMBER_MASTER-1:0] pick_grant;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_valid;

  logic aw_hs, w_hs, b_hs, err_hs, wd_expired;

  axil_rr_pick #(.N(NUMBER_MASTER)) u_pick (
    .request   (request_wr),
    .last_idx  (last_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .valid     (pick_valid)
  );

  assign aw_hs      = s_axil_awvalid && s_axil_awready;
  assign w_hs       = s_axil_wvalid && s_axil_wready;
  assign b_hs       = s_axil_bvalid && m_axil_bready[idx_q];
  assign err_hs     = m_axil_bready[idx_q];
  assign wd_expired = (wd_q == WD_MAX);

  // Next-state and next-output logic; a completing handshake beats expiry.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    err_d     = err_q;
    idx_d     = idx_q;
    last_d    = last_q;
    wd_d      = wd_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = ADDR_DATA;
          grant_d   = pick_grant;
          idx_d     = pick_idx;
          last_d    = pick_idx;
          wd_d      = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ADDR_DATA: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        // Saturate so a late completion keeps RESP inside the same window.
        wd_d      = wd_expired ? wd_q : wd_q + WD_W'(1);
        if (aw_done_d && w_done_d) begin
          state_d = RESP;
        end else if (wd_expired) begin
          state_d   = ERR;
          grant_d   = '0;
          err_d     = grant_q;
          timeout_d = 1'b1;
        end
      end
      RESP: begin
        wd_d = wd_expired ? wd_q : wd_q + WD_W'(1);
        if (b_hs) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (wd_expired) begin
          state_d   = ERR;
          grant_d   = '0;
          err_d     = grant_q;
          timeout_d = 1'b1;
        end
      end
      ERR: begin
        if (err_hs) begin
          state_d = IDLE;
          err_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      err_q     <= '0;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUMBER_MASTER - 1);
      wd_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_wr   = grant_q;
  assign grant_idx  = idx_q;
  assign err_bvalid = err_q;
  assign timeout    = timeout_q;

endmodule
